// File: rtl/uart_rx_keycode_pkg.sv
// uart_rx_keycode_pkg: shared state type and helpers for the keypad-link UART receiver
package uart_rx_keycode_pkg;
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} rx_state_e;
  function automatic int bit_cycles(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction
  function automatic int half_cycles(input int clk_freq, input int baudrate);
    return bit_cycles(clk_freq, baudrate) / 2;
  endfunction
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [1:0] idx4(input logic [3:0] v);
    return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver - input synchronizer, bit FSM, baud counter and shift register
module uart_rx_core
  import uart_rx_keycode_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUDRATE = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       byte_done_o,
  output logic       frame_err_o
);
  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUDRATE);
  localparam int HALF_CYCLES = half_cycles(CLK_FREQ, BAUDRATE);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] ARM_SETTLE = CW'(2);
  logic [1:0] sync_q;
  logic rx_s;
  logic expired;
  rx_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic done_q;
  logic ferr_q;
  assign rx_s = sync_q[1];
  assign expired = cnt_q == '0;
  // ARM first lets the synchronizer flush its reset value so a line still low after reset is not taken as idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      state_q <= ARM;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        ARM:
          if (cnt_q != ARM_SETTLE) cnt_q <= cnt_q + CW'(1);
          else if (rx_s) state_q <= IDLE;
        IDLE:
          if (!rx_s) begin
            cnt_q <= HALF_LOAD;
            state_q <= START;
          end
        START:
          if (!expired) cnt_q <= cnt_q - CW'(1);
          else if (rx_s) state_q <= IDLE;
          else begin
            cnt_q <= BIT_LOAD;
            bit_q <= '0;
            state_q <= DATA;
          end
        DATA:
          if (!expired) cnt_q <= cnt_q - CW'(1);
          else begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt_q <= BIT_LOAD;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        STOP:
          if (!expired) cnt_q <= cnt_q - CW'(1);
          else begin
            done_q <= rx_s;
            ferr_q <= !rx_s;
            state_q <= rx_s ? IDLE : ARM;
          end
        default: state_q <= ARM;
      endcase
    end
  end
  assign data_o = shift_q;
  assign byte_done_o = done_q;
  assign frame_err_o = ferr_q;
endmodule

// File: rtl/uart_rx_keycode.sv
// uart_rx_keycode: keypad-link UART receiver with scan-code decode and a valid/ready output register
module uart_rx_keycode
  import uart_rx_keycode_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUDRATE = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic [3:0] key_idx,
  output logic       key_ok,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);
  logic [7:0] byte_w;
  logic done_w;
  logic ferr_w;
  logic [7:0] data_q;
  logic [3:0] idx_q;
  logic [3:0] idx_d;
  logic ok_q;
  logic ok_d;
  logic valid_q;
  logic ferr_q;
  logic ovr_q;
  logic load;
  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUDRATE(BAUDRATE)
  ) u_core (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx_i  (uart_rx),
    .data_o     (byte_w),
    .byte_done_o(done_w),
    .frame_err_o(ferr_w)
  );
  always_comb begin
    ok_d = onehot4(byte_w[7:4]) && onehot4(byte_w[3:0]);
    idx_d = ok_d ? {idx4(byte_w[7:4]), idx4(byte_w[3:0])} : 4'd0;
    load = done_w && (!valid_q || rx_ready);
  end
  // A byte completing while the held one is being consumed replaces it without a gap in rx_valid
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= '0;
      idx_q <= '0;
      ok_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_w;
      ovr_q <= done_w && !load;
      if (load) begin
        data_q <= byte_w;
        idx_q <= idx_d;
        ok_q <= ok_d;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) valid_q <= 1'b0;
    end
  end
  assign rx_data = data_q;
  assign key_idx = idx_q;
  assign key_ok = ok_q;
  assign rx_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_keycode.sv
// tb_uart_rx_keycode: directed scenarios for the keypad-link UART receiver
module tb_uart_rx_keycode;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rx = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [3:0] key_idx;
  logic key_ok;
  logic rx_valid;
  logic frame_err;
  logic overrun;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int rises = 0;
  int fe_hi = 0;
  int ov_hi = 0;
  int both = 0;
  logic prev_v = 1'b0;
  logic [12:0] xq[$];
  uart_rx_keycode dut (
    .clk      (clk),
    .resetn   (resetn),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .key_idx  (key_idx),
    .key_ok   (key_ok),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Observes outputs mid-cycle: rx_valid rises, completed transfers, pulse cycles
  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      rises++;
      rise_cyc = cyc;
    end
    prev_v = rx_valid;
    if (rx_valid && rx_ready) xq.push_back({key_ok, key_idx, rx_data});
    if (frame_err) fe_hi++;
    if (overrun) ov_hi++;
    if (frame_err && overrun) both++;
  end
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int bc, input logic stop);
    start_cyc = cyc;
    uart_rx = 1'b0;
    hold(bc);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      hold(bc);
    end
    uart_rx = stop;
    hold(bc);
  endtask
  task automatic drain;
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
    hold(1);
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    hold(5);
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== 14'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", {rx_valid, rx_data, key_idx, key_ok}); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {frame_err, overrun}); end
    resetn = 1'b1;
    hold(10);
  endtask
  task automatic test_single;
    int r0;
    r0 = rises;
    xq.delete();
    send(8'h11, 104, 1'b1);
    checks++; if (rises != r0 + 1 || rise_cyc - start_cyc != 992) begin failures++; $display("FAIL single_latency got=%0d rises=%0d exp=992 rises=1", rise_cyc - start_cyc, rises - r0); end
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== {1'b1, 8'h11, 4'h0, 1'b1}) begin failures++; $display("FAIL single_out got=%h exp=%h", {rx_valid, rx_data, key_idx, key_ok}, {1'b1, 8'h11, 4'h0, 1'b1}); end
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_fall got=%b exp=0", rx_valid); end
    checks++; if (xq.size() != 1 || xq[0] !== {1'b1, 4'h0, 8'h11}) begin failures++; $display("FAIL single_xfer got_n=%0d exp_n=1", xq.size()); end
  endtask
  task automatic test_back_to_back;
    int o0;
    o0 = ov_hi;
    xq.delete();
    rx_ready = 1'b1;
    send(8'h84, 104, 1'b1);
    send(8'h33, 104, 1'b1);
    hold(20);
    rx_ready = 1'b0;
    checks++; if (xq.size() != 2 || xq[0] !== {1'b1, 4'hE, 8'h84} || xq[1] !== {1'b0, 4'h0, 8'h33}) begin failures++; $display("FAIL b2b_xfer got_n=%0d exp_n=2", xq.size()); end
    checks++; if (ov_hi != o0 || rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_state got_ovr=%0d valid=%b exp 0 0", ov_hi - o0, rx_valid); end
  endtask
  task automatic test_overrun;
    int o0;
    o0 = ov_hi;
    xq.delete();
    send(8'h21, 104, 1'b1);
    send(8'h42, 104, 1'b1);
    hold(20);
    checks++; if (ov_hi != o0 + 1) begin failures++; $display("FAIL ovr_pulse got=%0d exp=1", ov_hi - o0); end
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== {1'b1, 8'h21, 4'h4, 1'b1}) begin failures++; $display("FAIL ovr_hold got=%h exp=%h", {rx_valid, rx_data, key_idx, key_ok}, {1'b1, 8'h21, 4'h4, 1'b1}); end
    drain();
    checks++; if (xq.size() != 1 || xq[0] !== {1'b1, 4'h4, 8'h21} || rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got_n=%0d valid=%b exp_n=1 valid=0", xq.size(), rx_valid); end
    send(8'h21, 104, 1'b1);
    xq.delete();
    o0 = ov_hi;
    fork
      send(8'h42, 104, 1'b1);
      begin
        hold(991);
        rx_ready = 1'b1;
        hold(1);
        rx_ready = 1'b0;
      end
    join
    checks++; if (ov_hi != o0) begin failures++; $display("FAIL same_cycle_ovr got=%0d exp=0", ov_hi - o0); end
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== {1'b1, 8'h42, 4'h9, 1'b1}) begin failures++; $display("FAIL same_cycle_out got=%h exp=%h", {rx_valid, rx_data, key_idx, key_ok}, {1'b1, 8'h42, 4'h9, 1'b1}); end
    checks++; if (xq.size() != 1 || xq[0] !== {1'b1, 4'h4, 8'h21}) begin failures++; $display("FAIL same_cycle_xfer got_n=%0d exp_n=1", xq.size()); end
    drain();
  endtask
  task automatic test_glitch;
    int r0;
    int f0;
    r0 = rises;
    f0 = fe_hi;
    uart_rx = 1'b0;
    hold(20);
    uart_rx = 1'b1;
    hold(200);
    checks++; if (rises != r0 || fe_hi != f0) begin failures++; $display("FAIL glitch got_valid=%0d ferr=%0d exp 0 0", rises - r0, fe_hi - f0); end
    send(8'h18, 104, 1'b1);
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== {1'b1, 8'h18, 4'h3, 1'b1}) begin failures++; $display("FAIL glitch_next got=%h exp=%h", {rx_valid, rx_data, key_idx, key_ok}, {1'b1, 8'h18, 4'h3, 1'b1}); end
    drain();
  endtask
  task automatic test_frame_err;
    int r0;
    int f0;
    r0 = rises;
    f0 = fe_hi;
    send(8'h55, 104, 1'b0);
    hold(312);
    uart_rx = 1'b1;
    hold(300);
    checks++; if (fe_hi != f0 + 1 || rises != r0) begin failures++; $display("FAIL ferr got_ferr=%0d valid=%0d exp 1 0", fe_hi - f0, rises - r0); end
    send(8'h82, 104, 1'b1);
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== {1'b1, 8'h82, 4'hD, 1'b1}) begin failures++; $display("FAIL ferr_next got=%h exp=%h", {rx_valid, rx_data, key_idx, key_ok}, {1'b1, 8'h82, 4'hD, 1'b1}); end
    drain();
  endtask
  task automatic test_reset_mid;
    int r0;
    int f0;
    r0 = rises;
    f0 = fe_hi;
    fork
      send(8'h0F, 104, 1'b1);
      begin
        hold(560);
        resetn = 1'b0;
        hold(4);
        resetn = 1'b1;
      end
    join
    hold(300);
    checks++; if (rises != r0 || fe_hi != f0 || rx_valid !== 1'b0) begin failures++; $display("FAIL reset_mid got_valid=%0d ferr=%0d exp 0 0", rises - r0, fe_hi - f0); end
    send(8'h48, 104, 1'b1);
    checks++; if ({rx_valid, rx_data, key_idx, key_ok} !== {1'b1, 8'h48, 4'hB, 1'b1}) begin failures++; $display("FAIL reset_next got=%h exp=%h", {rx_valid, rx_data, key_idx, key_ok}, {1'b1, 8'h48, 4'hB, 1'b1}); end
    drain();
  endtask
  task automatic test_baud;
    xq.delete();
    rx_ready = 1'b1;
    send(8'h11, 102, 1'b1);
    send(8'h11, 106, 1'b1);
    hold(20);
    rx_ready = 1'b0;
    checks++; if (xq.size() != 2 || xq[0] !== {1'b1, 4'h0, 8'h11} || xq[1] !== {1'b1, 4'h0, 8'h11}) begin failures++; $display("FAIL baud_tol got_n=%0d exp_n=2", xq.size()); end
  endtask
  task automatic test_pulses;
    checks++; if (both != 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=0", both); end
    checks++; if (fe_hi != 1 || ov_hi != 1) begin failures++; $display("FAIL pulse_width got_ferr=%0d ovr=%0d exp 1 1", fe_hi, ov_hi); end
  endtask
  initial begin
    hold(2);
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_baud();
    test_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
